// File: rtl/vit_trb_decision_arb.sv
// Round-robin arbiter that shares one pipelined min-state decision tree among
// several Viterbi ACS channels and tags each tree issue with its owner channel.
module vit_trb_decision_arb #(
    parameter int pCONSTR_LENGTH = 3,
    parameter int pCHAN_NUM      = 4,
    localparam int cTREE_LAT     = pCONSTR_LENGTH - 1,
    localparam int cSB_W         = pCONSTR_LENGTH - 1,
    localparam int cCH_W         = $clog2(pCHAN_NUM)
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic                 iclear,
    input  logic [pCHAN_NUM-1:0] ireq,
    output logic [pCHAN_NUM-1:0] ogrant,
    output logic [cCH_W-1:0]     osel,
    output logic                 otree_val,
    input  logic                 itree_val,
    input  logic [cSB_W-1:0]     itree_state,
    output logic                 odone_val,
    output logic [cCH_W-1:0]     odone_chan,
    output logic [cSB_W-1:0]     odone_state,
    output logic                 osync_err,
    output logic                 obusy
);

    logic [pCHAN_NUM-1:0]            pending_q;
    logic [pCHAN_NUM-1:0]            grant_q;
    logic [cCH_W-1:0]                sel_q;
    logic                            tval_q;
    logic [cCH_W-1:0]                rr_q;
    logic [cTREE_LAT-1:0]            tag_v_q;
    logic [cTREE_LAT-1:0][cCH_W-1:0] tag_c_q;
    logic                            sync_err_q;

    logic [pCHAN_NUM-1:0] req_eff;
    logic [pCHAN_NUM-1:0] grant_d;
    logic [cCH_W-1:0]     win_idx;
    logic [cCH_W-1:0]     cand_idx;
    logic                 win_found;

    // Rotating search starting just after the last winner.
    always_comb begin
        req_eff   = pending_q | ireq;
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        grant_d   = '0;
        for (int unsigned k = 1; k <= pCHAN_NUM; k++) begin
            cand_idx = cCH_W'((32'(rr_q) + k) % pCHAN_NUM);
            if (!win_found && req_eff[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        if (win_found) begin
            grant_d[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            pending_q  <= '0;
            grant_q    <= '0;
            sel_q      <= '0;
            tval_q     <= 1'b0;
            rr_q       <= cCH_W'(pCHAN_NUM - 1);
            tag_v_q    <= '0;
            tag_c_q    <= '0;
            sync_err_q <= 1'b0;
        end else if (iclkena) begin
            if (itree_val != tag_v_q[cTREE_LAT-1]) begin
                sync_err_q <= 1'b1;
            end
            tag_c_q[0] <= sel_q;
            for (int unsigned s = 1; s < cTREE_LAT; s++) begin
                tag_c_q[s] <= tag_c_q[s-1];
            end
            if (iclear) begin
                pending_q <= '0;
                grant_q   <= '0;
                tval_q    <= 1'b0;
                tag_v_q   <= '0;
            end else begin
                pending_q <= req_eff & ~grant_d;
                grant_q   <= grant_d;
                tval_q    <= win_found;
                if (win_found) begin
                    sel_q <= win_idx;
                    rr_q  <= win_idx;
                end
                tag_v_q[0] <= tval_q;
                for (int unsigned s = 1; s < cTREE_LAT; s++) begin
                    tag_v_q[s] <= tag_v_q[s-1];
                end
            end
        end
    end

    assign ogrant      = grant_q;
    assign osel        = sel_q;
    assign otree_val   = tval_q;
    assign odone_val   = itree_val & tag_v_q[cTREE_LAT-1];
    assign odone_chan  = tag_c_q[cTREE_LAT-1];
    assign odone_state = itree_state;
    assign osync_err   = sync_err_q;
    assign obusy       = (|pending_q) | (|tag_v_q) | tval_q;

endmodule

// File: tb/tb_vit_trb_decision_arb.sv
// Scoreboard bench for vit_trb_decision_arb: reference arbiter model plus a
// behavioural decision-tree model with optional extra latency.
module tb_vit_trb_decision_arb;

    localparam int K   = 3;
    localparam int N   = 4;
    localparam int LAT = K - 1;
    localparam int SB  = K - 1;
    localparam int CW  = $clog2(N);

    logic          iclk = 1'b0;
    logic          ireset = 1'b1;
    logic          iclkena = 1'b1;
    logic          iclear = 1'b0;
    logic [N-1:0]  ireq = '0;
    logic [N-1:0]  ogrant;
    logic [CW-1:0] osel;
    logic          otree_val;
    logic          itree_val;
    logic [SB-1:0] itree_state;
    logic          odone_val;
    logic [CW-1:0] odone_chan;
    logic [SB-1:0] odone_state;
    logic          osync_err;
    logic          obusy;

    vit_trb_decision_arb #(.pCONSTR_LENGTH(K), .pCHAN_NUM(N)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iclear(iclear),
        .ireq(ireq), .ogrant(ogrant), .osel(osel), .otree_val(otree_val),
        .itree_val(itree_val), .itree_state(itree_state),
        .odone_val(odone_val), .odone_chan(odone_chan), .odone_state(odone_state),
        .osync_err(osync_err), .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Decision tree model: fixed-latency valid pipe carrying a random state.
    logic              extra = 1'b0;
    logic [LAT:0]      tv;
    logic [LAT:0][SB-1:0] ts;
    always @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            tv <= '0;
            ts <= '0;
        end else if (iclkena) begin
            if (iclear) tv <= '0;
            else        tv <= {tv[LAT-1:0], otree_val};
            ts <= {ts[LAT-1:0], SB'($urandom)};
        end
    end
    assign itree_val   = extra ? tv[LAT] : tv[LAT-1];
    assign itree_state = extra ? ts[LAT] : ts[LAT-1];

    // Reference model: pending set, last-served pointer, issue log.
    typedef struct { int unsigned ch; int unsigned t; } ent_t;
    ent_t          sbq[$];
    int unsigned   ecount;
    logic [N-1:0]  m_pend, m_grant;
    int unsigned   m_sel, m_last;
    logic          m_tval;
    always @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            m_pend = '0; m_grant = '0; m_sel = 0; m_last = N - 1; m_tval = 1'b0;
            ecount = 0;
            sbq.delete();
        end else if (iclkena) begin
            ecount++;
            if (iclear) begin
                m_pend = '0; m_grant = '0; m_tval = 1'b0;
                sbq.delete();
            end else begin
                logic [N-1:0] want;
                int           w;
                want = m_pend | ireq;
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && want[(m_last + k) % N]) w = (m_last + k) % N;
                if (w >= 0) begin
                    m_grant = N'(1) << w;
                    m_sel = w; m_last = w; m_tval = 1'b1;
                    sbq.push_back('{ch: w, t: ecount});
                end else begin
                    m_grant = '0; m_tval = 1'b0;
                end
                m_pend = want & ~m_grant;
            end
        end
    end

    // Monitor: per-cycle registered outputs and result pops.
    logic chk_en = 1'b1;
    always @(negedge iclk) begin
        if (!ireset && chk_en) begin
            chk("ogrant", ogrant, m_grant);
            chk("osel", osel, m_sel);
            chk("otree_val", otree_val, m_tval);
            chk("osync_err", osync_err, 0);
            chk("obusy", obusy, int'(m_pend != 0 || m_tval || sbq.size() != 0));
            if (iclkena) begin
                logic exp_dv;
                exp_dv = sbq.size() != 0 && sbq[0].t + LAT == ecount;
                chk("odone_val", odone_val, exp_dv);
                if (exp_dv) begin
                    ent_t e;
                    e = sbq.pop_front();
                    if (odone_val) begin
                        chk("odone_chan", odone_chan, e.ch);
                        chk("odone_state", odone_state, itree_state);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic en, input logic clr);
        ireq = r; iclkena = en; iclear = clr;
        @(posedge iclk); #1;
    endtask

    task automatic reset_dut();
        ireq = '0; iclkena = 1'b1; iclear = 1'b0; ireset = 1'b1;
        @(posedge iclk); #1;
        ireset = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_ogrant", ogrant, 0);
        chk("rst_osel", osel, 0);
        chk("rst_otree_val", otree_val, 0);
        chk("rst_osync_err", osync_err, 0);
        chk("rst_obusy", obusy, 0);
        chk("rst_odone_val", odone_val, 0);
    endtask

    initial begin
        reset_dut();
        chk_reset_vals();

        // Single request on channel 2.
        cyc(4'b0100, 1, 0);
        chk("single_grant", ogrant, 4'b0100);
        chk("single_sel", osel, 2);
        cyc('0, 1, 0);
        cyc('0, 1, 0);
        chk("single_done", odone_val, 1);
        chk("single_chan", odone_chan, 2);

        // Full burst from a fresh pointer: order 0..3, idle after drain.
        reset_dut();
        cyc(4'b1111, 1, 0);
        chk("burst_sel0", osel, 0);
        for (int i = 1; i < N; i++) begin
            cyc('0, 1, 0);
            chk("burst_sel", osel, i);
        end
        for (int i = 0; i < LAT + 1; i++) cyc('0, 1, 0);
        chk("burst_idle", obusy, 0);

        // Fairness: channel 1 always requesting, channel 3 once.
        reset_dut();
        cyc(4'b1010, 1, 0); chk("fair0", osel, 1);
        cyc(4'b0010, 1, 0); chk("fair1", osel, 3);
        cyc(4'b0010, 1, 0); chk("fair2", osel, 1);
        cyc(4'b0010, 1, 0); chk("fair3", osel, 1);
        for (int i = 0; i < 4; i++) cyc('0, 1, 0);

        // Flush while a request is pending and a tag is about to launch.
        reset_dut();
        cyc(4'b1010, 1, 0);
        cyc(4'b0001, 1, 1);
        chk("clr_grant", ogrant, 0);
        chk("clr_tval", otree_val, 0);
        chk("clr_busy", obusy, 0);
        for (int i = 0; i < 3; i++) begin
            cyc('0, 1, 0);
            chk("clr_nogrant", ogrant, 0);
        end

        // Clock-enable toggling during a burst.
        cyc(4'b1111, 1, 0);
        for (int i = 0; i < 12; i++) cyc('0, logic'(i % 2), 0);
        for (int i = 0; i < 4; i++) cyc('0, 1, 0);

        // Randomized traffic with gaps and occasional flushes.
        for (int i = 0; i < 600; i++)
            cyc(N'($urandom & $urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 40) == 0);
        for (int i = 0; i < N + LAT + 2; i++) cyc('0, 1, 0);
        chk("drain_queue", sbq.size(), 0);
        chk("drain_busy", obusy, 0);

        // Tree one stage slower than the tag pipe: sticky sync error.
        reset_dut();
        chk_en = 1'b0;
        extra  = 1'b1;
        cyc(4'b0001, 1, 0);
        cyc('0, 1, 0);
        cyc('0, 1, 0);
        chk("sync_before", osync_err, 0);
        cyc('0, 1, 0);
        chk("sync_set", osync_err, 1);
        for (int i = 0; i < 4; i++) cyc('0, 1, 0);
        chk("sync_sticky", osync_err, 1);
        extra = 1'b0;
        reset_dut();
        chk_reset_vals();
        chk_en = 1'b1;
        cyc(4'b1000, 1, 0);
        for (int i = 0; i < 4; i++) cyc('0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
